bram_loader: RTL and testbench
==============================

# bram_loader

Boot-time controller that fills the instruction and data BRAMs of the rv32i single-core CPU from a byte stream (UART receiver or debug host) and then releases the CPU. It drives the BRAM write ports (`w_addr`/`w_dat`/`w_enb`) of both `bram32` instances and the PC `stall` input. This replaces the bench-side loading loops, so the same load sequence works in simulation and on the Zybo Z7-20.

## Interface
- `MAX_WORDS`, default 256: maximum words per load command. This is the BRAM depth: a 10-bit byte address space divided by 4.
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_dat`  in  8  stream byte.
- `s_valid`  in  1  `s_dat` is valid.
- `s_ready`  out  1  loader can accept a byte. A byte is transferred on an edge where `s_valid && s_ready`.
- `i_w_addr`  out  10  instruction BRAM write byte address.
- `i_w_dat`  out  32  instruction BRAM write data.
- `i_w_enb`  out  1  instruction BRAM write enable.
- `d_w_addr`  out  10  data BRAM write byte address.
- `d_w_dat`  out  32  data BRAM write data.
- `d_w_enb`  out  1  data BRAM write enable.
- `cpu_stall`  out  1  connects to PC `stall`; 1 holds the CPU.
- `cpu_run`  out  1  1 once the CPU has been released. Also drives the instruction BRAM `r_enb` and the regfile `read_enable`.
- `error`  out  1  sticky protocol error.

## Operation
- Command format:
  - Byte 0 is the command: `0x49` ('I') loads the instruction BRAM, `0x44` ('D') loads the data BRAM, `0x47` ('G') releases the CPU.
  - 'I' and 'D' are followed by a 16-bit word count N, low byte first.
  - Then come N×4 payload bytes. Each word is assembled little-endian: the first byte goes to bits [7:0].
- States:
  - IDLE: accepts the command byte.
    - 'I' or 'D' → LEN_LO, latching the target BRAM.
    - 'G' → RUN.
    - Any other byte → ERROR.
  - LEN_LO: accepts the count low byte → LEN_HI.
  - LEN_HI: accepts the count high byte.
    - N=0 → IDLE.
    - N>MAX_WORDS → ERROR.
    - Otherwise → DATA, with byte index 0 and address 0.
  - DATA: accepts bytes into the word shift register. After byte index 3 → WRITE.
  - WRITE: the selected `*_w_enb`=1 for this one cycle, with `*_w_addr` and `*_w_dat` stable. On the closing edge, address += 4 and remaining -= 1.
    - Remaining now 0 → IDLE.
    - Otherwise → DATA.
  - RUN: `cpu_stall`=0, `cpu_run`=1. Terminal until `rst`.
  - ERROR: `error`=1. Terminal until `rst`.
- `s_ready` is decoded from state: 1 in IDLE, LEN_LO, LEN_HI and DATA; 0 in WRITE, RUN and ERROR.
- Each 'I'/'D' command restarts its address at 0. Reloading overwrites earlier words.
- The unselected BRAM's enable stays 0. Address and data outputs hold their last values when not writing.
- Write address arithmetic is 10-bit. With N≤MAX_WORDS it never wraps; the last address written is 4×(N−1).
- `s_valid` may drop for any number of cycles in any accepting state. The state and partial word then hold.

## Timing
- Reset values:
  - State is IDLE.
  - `s_ready`=1, `cpu_stall`=1, `cpu_run`=0, `error`=0.
  - Both enables are 0.
  - Both addresses and both data outputs are 0.
  - Byte index, count and word register are cleared.
- `rst` applied mid-command aborts it: no write is issued and the partial word is discarded.
- Write latency: the 4th payload byte is accepted on edge k. `*_w_enb` is high for cycle k→k+1, and the BRAM captures on edge k+1.
- Throughput: at most one word per 5 cycles under continuous `s_valid`.
- 'G' accepted on edge k: `cpu_stall`=0 and `cpu_run`=1 from edge k onward.
- Error detection: ERROR is entered on the edge that accepts the offending byte (bad command, or an oversized count high byte).
- There is no simultaneous-event conflict: only one byte is consumed per cycle and WRITE accepts none.

## Test plan
- Reset, then idle with `s_valid`=0 for 10 cycles → `s_ready`=1, `cpu_stall`=1, `cpu_run`=0, `error`=0, both enables 0 throughout.
- Stream `49 02 00 | 13 05 00 00 | 93 05 10 00` → exactly two `i_w_enb` pulses: (0x000, 0x00000513), then (0x004, 0x00100593). `d_w_enb` never asserts; state returns to IDLE.
- Stream `44 04 00` + words 1, 2, 3, 4 (LE), with `s_valid` low for 3 cycles between every byte → `d_w_enb` pulses at 0x000, 0x004, 0x008, 0x00C with data 0x1, 0x2, 0x3, 0x4. Each pulse is one cycle long.
- Then stream `47` → `cpu_stall`=0 and `cpu_run`=1 after the accepting edge. `s_ready`=0. Further bytes are ignored and no enables assert.
- Error cases:
  - Stream `55` → `error`=1, `s_ready`=0, held for 20 cycles.
  - Apply `rst` → `error`=0.
  - Stream `49 01 01` (N=257) → `error`=1 and no write occurs.
  - `49 00 00` (N=0) → back to IDLE with no write.
- Stream `49 01 00 AA BB`, assert `rst` for one cycle, then `49 01 00 11 22 33 44` → a single write: `i_w_addr`=0x000, `i_w_dat`=0x44332211.

Source files
------------

// File: rtl/bram_loader.sv
// Boot loader: parses 'I'/'D'/'G' commands from a byte stream, writes
// little-endian words into the instruction or data BRAM, then releases the CPU.
module bram_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_dat,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [9:0]  i_w_addr,
  output logic [31:0] i_w_dat,
  output logic        i_w_enb,
  output logic [9:0]  d_w_addr,
  output logic [31:0] d_w_dat,
  output logic        d_w_enb,
  output logic        cpu_stall,
  output logic        cpu_run,
  output logic        error,
  output logic [2:0]  o_dbg_state
);

  // Stream handshake: a byte moves on a rising edge where s_valid && s_ready;
  // s_ready depends only on state, never on s_valid.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  localparam logic [16:0] LP_MAX = 17'(MAX_WORDS);

  state_t      r_state;
  state_t      w_next;
  logic        r_sel_d;
  logic [7:0]  r_len_lo;
  logic [15:0] r_cnt;
  logic [1:0]  r_idx;
  logic [23:0] r_word;
  logic [9:0]  r_addr;

  logic        w_accept;
  logic [15:0] w_len;
  logic        w_len_bad;
  logic [31:0] w_word_next;

  assign w_accept    = s_valid && s_ready;
  assign w_len       = {s_dat, r_len_lo};
  assign w_len_bad   = {1'b0, w_len} > LP_MAX;
  // Earlier bytes sit in the low bits, so the word completes with s_dat on top.
  assign w_word_next = {s_dat, r_word};
  assign o_dbg_state = r_state;

  always_comb begin
    w_next    = r_state;
    s_ready   = 1'b0;
    i_w_enb   = 1'b0;
    d_w_enb   = 1'b0;
    cpu_stall = 1'b1;
    cpu_run   = 1'b0;
    error     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (w_accept) begin
          if (s_dat == 8'h49 || s_dat == 8'h44) w_next = ST_LEN_LO;
          else if (s_dat == 8'h47)              w_next = ST_RUN;
          else                                  w_next = ST_ERROR;
        end
      end
      ST_LEN_LO: begin
        s_ready = 1'b1;
        if (w_accept) w_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        s_ready = 1'b1;
        if (w_accept) begin
          if (w_len == 16'd0) w_next = ST_IDLE;
          else if (w_len_bad) w_next = ST_ERROR;
          else                w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        s_ready = 1'b1;
        if (w_accept && r_idx == 2'd3) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        i_w_enb = !r_sel_d;
        d_w_enb = r_sel_d;
        w_next  = (r_cnt == 16'd1) ? ST_IDLE : ST_DATA;
      end
      ST_RUN: begin
        cpu_stall = 1'b0;
        cpu_run   = 1'b1;
      end
      ST_ERROR: begin
        error = 1'b1;
      end
      default: w_next = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sel_d  <= 1'b0;
      r_len_lo <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_word   <= '0;
      r_addr   <= '0;
      i_w_addr <= '0;
      i_w_dat  <= '0;
      d_w_addr <= '0;
      d_w_dat  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (w_accept) r_sel_d <= (s_dat == 8'h44);
        ST_LEN_LO: if (w_accept) r_len_lo <= s_dat;
        ST_LEN_HI: begin
          if (w_accept) begin
            r_cnt  <= w_len;
            r_addr <= '0;
            r_idx  <= '0;
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_word <= w_word_next[31:8];
            r_idx  <= r_idx + 2'd1;
            // Output registers load once per word and hold until the next one.
            if (r_idx == 2'd3) begin
              if (r_sel_d) begin
                d_w_addr <= r_addr;
                d_w_dat  <= w_word_next;
              end else begin
                i_w_addr <= r_addr;
                i_w_dat  <= w_word_next;
              end
            end
          end
        end
        ST_WRITE: begin
          r_addr <= r_addr + 10'd4;
          r_cnt  <= r_cnt - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_loader.sv
// Randomized bench for bram_loader: expected BRAM writes come from command
// contents (word i of a load lands at byte address 4*i) and are checked by a monitor.
module tb_bram_loader;
  localparam int W         = 43;
  localparam int MAX_WORDS = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_dat;
  logic        s_valid;
  logic        s_ready;
  logic [9:0]  i_w_addr;
  logic [31:0] i_w_dat;
  logic        i_w_enb;
  logic [9:0]  d_w_addr;
  logic [31:0] d_w_dat;
  logic        d_w_enb;
  logic        cpu_stall;
  logic        cpu_run;
  logic        error;
  logic [2:0]  o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic prev_en = 1'b0;

  bram_loader #(.MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .s_dat(s_dat), .s_valid(s_valid), .s_ready(s_ready),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb),
    .cpu_stall(cpu_stall), .cpu_run(cpu_run), .error(error),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    check("rst_s_ready",   s_ready, 1);
    check("rst_cpu_stall", cpu_stall, 1);
    check("rst_cpu_run",   cpu_run, 0);
    check("rst_error",     error, 0);
    check("rst_enables",   {i_w_enb, d_w_enb}, 0);
    check("rst_addrs",     {i_w_addr, d_w_addr}, 0);
    check("rst_dats",      {i_w_dat, d_w_dat}, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    s_dat   = b;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      check("handshake_timeout", 0, 1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic load(input logic is_d, input logic [31:0] words[$], input int gap);
    int n;
    n = words.size();
    for (int i = 0; i < n; i++) exp_q.push_back({is_d, 10'(4 * i), words[i]});
    send_byte(is_d ? 8'h44 : 8'h49, gap);
    send_byte(8'(n), gap);
    send_byte(8'(n >> 8), gap);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) send_byte(8'(words[i] >> (8 * b)), gap);
      // Just after the edge that took the 4th byte the enable must be up.
      check("write_latency", is_d ? d_w_enb : i_w_enb, 1);
    end
  endtask

  task automatic drive_ignored(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      s_dat   = 8'($urandom_range(0, 255));
      s_valid = 1'b1;
      check("terminal_s_ready", s_ready, 0);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (i_w_enb || d_w_enb) begin
        check("single_enable", {i_w_enb, d_w_enb} == 2'b11, 0);
        check("pulse_width", prev_en, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", {d_w_enb, i_w_enb, i_w_addr, d_w_addr}, 0);
        end else begin
          e = exp_q.pop_front();
          check("write", d_w_enb ? {1'b1, d_w_addr, d_w_dat} : {1'b0, i_w_addr, i_w_dat}, e);
        end
      end
      prev_en = i_w_enb || d_w_enb;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] wq[$];
    int n;
    rst = 1'b1;
    s_valid = 1'b0;
    s_dat = 8'h00;
    do_reset(2);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_s_ready", s_ready, 1);
      check("idle_outputs", {cpu_stall, cpu_run, error, i_w_enb, d_w_enb}, 5'b10000);
    end

    wq = '{32'h00000513, 32'h00100593};
    load(1'b0, wq, 0);
    wq = '{32'h1, 32'h2, 32'h3, 32'h4};
    load(1'b1, wq, 3);

    for (int k = 0; k < 8; k++) begin
      n = (k == 3) ? MAX_WORDS : $urandom_range(1, 12);
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      load(1'($urandom_range(0, 1)), wq, $urandom_range(0, 2));
    end

    send_byte(8'h47, 0);
    check("go_cpu_run",   {cpu_stall, cpu_run}, 2'b01);
    check("go_s_ready",   s_ready, 0);
    drive_ignored(6);
    check("go_held",      {cpu_stall, cpu_run, error}, 3'b010);

    do_reset(1);
    send_byte(8'h55, 0);
    check("bad_cmd_error", error, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bad_cmd_hold", {error, s_ready}, 2'b10);
    end

    do_reset(1);
    send_byte(8'h49, 0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("oversize_error", error, 1);
    drive_ignored(8);

    do_reset(1);
    send_byte(8'h49, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("zero_len_ready", {s_ready, error}, 2'b10);
    wq = '{32'hCAFE_0001};
    load(1'b1, wq, 1);

    send_byte(8'h49, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    do_reset(1);
    wq = '{32'h44332211};
    load(1'b0, wq, 0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
